operand_fetch: RTL and testbench

- Consumer-side companion to the 32x32 register file: the read-port driver and operand-delivery stage between decode (ID) and execute (EX).
- Drives the register file read addresses and bypasses same-cycle write-back data, because a write is not visible on the combinational read until after the clock edge.
- Tracks in-flight destination registers in a busy scoreboard to interlock RAW/WAW hazards.
- Delivers registered operands to EX through a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/operand_fetch.sv | 131 +++++++++++++
 tb/tb_operand_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and operand-select helpers for the operand fetch stage.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // Where an operand comes from this cycle.
    typedef enum logic [1:0] {
        OPSEL_ZERO      = 2'd0,
        OPSEL_WB_BYPASS = 2'd1,
        OPSEL_RF        = 2'd2
    } opsel_e;

    // r0 reads as zero. A same-cycle write-back wins over the register file,
    // because the write only becomes visible on the read port after the edge.
    function automatic opsel_e op_select(input logic [ADDR_W-1:0] src,
                                         input logic              wb_wen,
                                         input logic [ADDR_W-1:0] wb_waddr);
        if (src == REG_ZERO)
            return OPSEL_ZERO;
        else if (wb_wen && (wb_waddr == src))
            return OPSEL_WB_BYPASS;
        else
            return OPSEL_RF;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per register marking an in-flight destination.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] lk_addr1,
    input  logic [ADDR_W-1:0] lk_addr2,
    input  logic [ADDR_W-1:0] lk_addr3,
    output logic              lk_busy1,
    output logic              lk_busy2,
    output logic              lk_busy3
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clear on write-back, then set on issue so a same-cycle
    // set of the same register wins. r0 never becomes busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en && (clr_addr != '0))
            busy_d[clr_addr] = 1'b0;
        if (set_en && (set_addr != '0))
            busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    // Lookups against the registered state.
    always_comb begin
        lk_busy1 = busy_q[lk_addr1];
        lk_busy2 = busy_q[lk_addr2];
        lk_busy3 = busy_q[lk_addr3];
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute: drives the register file
// read ports, bypasses same-cycle write-back, interlocks RAW/WAW hazards and
// hands registered operands to EX over valid/ready.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_wen,
    output logic [ADDR_W-1:0] raddr1,
    output logic [ADDR_W-1:0] raddr2,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic              wb_wen,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_src1,
    output logic [DATA_W-1:0] ex_src2,
    output logic [ADDR_W-1:0] ex_dest,
    output logic              ex_wen
);

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_src1_q,  ex_src1_d;
    logic [DATA_W-1:0] ex_src2_q,  ex_src2_d;
    logic [ADDR_W-1:0] ex_dest_q,  ex_dest_d;
    logic              ex_wen_q,   ex_wen_d;

    logic              busy_rs, busy_rt, busy_rd;
    logic              stall, issue;
    opsel_e            sel1, sel2;
    logic [DATA_W-1:0] op1, op2;

    assign raddr1 = id_rs;
    assign raddr2 = id_rt;

    reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue && id_wen),
        .set_addr (id_rd),
        .clr_en   (wb_wen),
        .clr_addr (wb_waddr),
        .lk_addr1 (id_rs),
        .lk_addr2 (id_rt),
        .lk_addr3 (id_rd),
        .lk_busy1 (busy_rs),
        .lk_busy2 (busy_rt),
        .lk_busy3 (busy_rd)
    );

    // Hazard interlock: a busy register is only released early by a matching
    // write-back in this same cycle (its data is bypassed).
    always_comb begin
        logic blk_rs, blk_rt, blk_rd;
        blk_rs   = (id_rs != '0) && busy_rs && !(wb_wen && (wb_waddr == id_rs));
        blk_rt   = (id_rt != '0) && busy_rt && !(wb_wen && (wb_waddr == id_rt));
        blk_rd   = id_wen && (id_rd != '0) && busy_rd && !(wb_wen && (wb_waddr == id_rd));
        stall    = blk_rs || blk_rt || blk_rd;
        id_ready = !reset && !stall && (!ex_valid_q || ex_ready);
        issue    = id_valid && id_ready;
    end

    // Operand select: zero, write-back bypass, or register file.
    always_comb begin
        sel1 = op_select(id_rs, wb_wen, wb_waddr);
        sel2 = op_select(id_rt, wb_wen, wb_waddr);
        case (sel1)
            OPSEL_ZERO:      op1 = '0;
            OPSEL_WB_BYPASS: op1 = wb_wdata;
            default:         op1 = rdata1;
        endcase
        case (sel2)
            OPSEL_ZERO:      op2 = '0;
            OPSEL_WB_BYPASS: op2 = wb_wdata;
            default:         op2 = rdata2;
        endcase
    end

    // EX stage next state: load on issue, drop valid once consumed, else hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_src1_d  = ex_src1_q;
        ex_src2_d  = ex_src2_q;
        ex_dest_d  = ex_dest_q;
        ex_wen_d   = ex_wen_q;
        if (issue) begin
            ex_valid_d = 1'b1;
            ex_src1_d  = op1;
            ex_src2_d  = op2;
            ex_dest_d  = id_rd;
            ex_wen_d   = id_wen;
        end else if (ex_valid_q && ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // EX stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_src1_q  <= '0;
            ex_src2_q  <= '0;
            ex_dest_q  <= '0;
            ex_wen_q   <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_src1_q  <= ex_src1_d;
            ex_src2_q  <= ex_src2_d;
            ex_dest_q  <= ex_dest_d;
            ex_wen_q   <= ex_wen_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_src1  = ex_src1_q;
    assign ex_src2  = ex_src2_q;
    assign ex_dest  = ex_dest_q;
    assign ex_wen   = ex_wen_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_wen;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_src1, ex_src2;
    logic [4:0]  ex_dest;
    logic        ex_wen;

    logic [31:0] rf [32];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_wen(id_wen),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest), .ex_wen(ex_wen)
    );

    // Behavioural register file: combinational read, write visible after edge.
    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];
    always @(posedge clk)
        if (wb_wen && wb_waddr != 5'd0) rf[wb_waddr] <= wb_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic wen);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_wen = wen;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_wen = en; wb_waddr = a; wb_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h11;
        reset = 1'b1;
        ex_ready = 1'b1;
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
        drive_wb(1'b0, 5'd0, 32'h0);

        // Reset state
        tick(); tick();
        check("rst_id_ready", {31'd0, id_ready}, 32'd0);
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ex_src1", ex_src1, 32'd0);
        check("rst_ex_dest", {27'd0, ex_dest}, 32'd0);
        check("rst_ex_wen", {31'd0, ex_wen}, 32'd0);
        reset = 1'b0;

        // Basic issue rs=1 rt=2
        settle();
        check("basic_ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("basic_valid", {31'd0, ex_valid}, 32'd1);
        check("basic_src1", ex_src1, 32'h11);
        check("basic_src2", ex_src2, 32'h22);

        // RAW on r3 released by write-back bypass
        drive_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        check("raw_dest", {27'd0, ex_dest}, 32'd3);
        check("raw_wen", {31'd0, ex_wen}, 32'd1);
        drive_id(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        settle();
        check("raw_stall0", {31'd0, id_ready}, 32'd0);
        tick();
        check("raw_drain", {31'd0, ex_valid}, 32'd0);
        check("raw_stall1", {31'd0, id_ready}, 32'd0);
        drive_wb(1'b1, 5'd3, 32'hABCD);
        settle();
        check("raw_bypass_ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("raw_bypass_src1", ex_src1, 32'hABCD);
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        check("raw_clear_ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("raw_rf_src1", ex_src1, 32'hABCD);

        // r0 stays zero, wb to r0 ignored
        drive_id(1'b1, 5'd0, 5'd1, 5'd0, 1'b1);
        drive_wb(1'b1, 5'd0, 32'hFFFF);
        tick();
        check("r0_src1", ex_src1, 32'd0);
        check("r0_src2", ex_src2, 32'h11);
        check("r0_busy", {31'd0, dut.u_sb.busy_q[0]}, 32'd0);
        drive_wb(1'b0, 5'd0, 32'h0);

        // Backpressure: EX held for 3 cycles, then back-to-back accept
        drive_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1);
        tick();
        check("bp_dest", {27'd0, ex_dest}, 32'd4);
        ex_ready = 1'b0;
        drive_id(1'b1, 5'd2, 5'd1, 5'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_ready_low", {31'd0, id_ready}, 32'd0);
            tick();
            check("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
            check("bp_hold_src1", ex_src1, 32'h11);
            check("bp_hold_dest", {27'd0, ex_dest}, 32'd4);
        end
        ex_ready = 1'b1;
        settle();
        check("bp_release_ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("bp_next_valid", {31'd0, ex_valid}, 32'd1);
        check("bp_next_src1", ex_src1, 32'h22);
        check("bp_next_src2", ex_src2, 32'h11);
        check("bp_next_dest", {27'd0, ex_dest}, 32'd6);

        // WAW on r5: stall, then same-cycle wb + reissue; set beats clear
        drive_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        tick();
        settle();
        check("waw_stall", {31'd0, id_ready}, 32'd0);
        drive_wb(1'b1, 5'd5, 32'h55);
        settle();
        check("waw_ready", {31'd0, id_ready}, 32'd1);
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        check("waw_busy5", {31'd0, dut.u_sb.busy_q[5]}, 32'd1);
        drive_id(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        settle();
        check("waw_raw_stall", {31'd0, id_ready}, 32'd0);

        // Reset mid-operation with r7 in flight
        drive_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        tick();
        check("mid_valid", {31'd0, ex_valid}, 32'd1);
        check("mid_busy7", {31'd0, dut.u_sb.busy_q[7]}, 32'd1);
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        check("mid_rst_src1", ex_src1, 32'd0);
        check("mid_rst_busy", dut.u_sb.busy_q, 32'd0);
        drive_id(1'b1, 5'd7, 5'd4, 5'd0, 1'b0);
        settle();
        check("post_rst_ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("post_rst_src1", ex_src1, 32'h77);
        check("post_rst_src2", ex_src2, 32'h44);

        // Write-back to a non-busy register: bypass, busy stays clear
        drive_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b0);
        drive_wb(1'b1, 5'd2, 32'h1234);
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("nb_bypass_src1", ex_src1, 32'h1234);
        check("nb_busy2", {31'd0, dut.u_sb.busy_q[2]}, 32'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
